// File: rtl/pipe_mips32_core.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with a unified word-addressed memory.
// Build option: define PIPE_MIPS32_MUL_EN to give opcode 000101 a single-cycle MUL; otherwise it is a NOP.
module pipe_mips32_core #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk1,
    input  logic rst_n,
    output logic halted
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BNEZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    // Architectural state; these names are reached hierarchically for program/data preload.
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] Reg [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        fetch_stop_r;

    logic        if_id_valid_r;
    logic [31:0] if_id_ir_r;
    logic [31:0] if_id_npc_r;

    logic        id_ex_valid_r;
    logic [31:0] id_ex_ir_r;
    logic [31:0] id_ex_npc_r;
    logic [31:0] id_ex_a_r;
    logic [31:0] id_ex_b_r;

    logic        ex_mem_valid_r;
    logic        ex_mem_wr_r;
    logic        ex_mem_load_r;
    logic        ex_mem_store_r;
    logic        ex_mem_hlt_r;
    logic [4:0]  ex_mem_rd_r;
    logic [31:0] ex_mem_alu_r;
    logic [31:0] ex_mem_b_r;

    logic        mem_wb_valid_r;
    logic        mem_wb_wr_r;
    logic        mem_wb_hlt_r;
    logic [4:0]  mem_wb_rd_r;
    logic [31:0] mem_wb_res_r;

    logic [31:0] pc_next_s;
    logic [31:0] if_ir_s;
    logic [4:0]  id_rs_s;
    logic [4:0]  id_rt_s;
    logic [31:0] id_a_s;
    logic [31:0] id_b_s;
    logic        id_hlt_s;
    logic        wb_we_s;
    logic [5:0]  ex_op_s;
    logic [4:0]  ex_rs_s;
    logic [4:0]  ex_rt_s;
    logic [31:0] ex_imm_s;
    logic [31:0] ex_a_s;
    logic [31:0] ex_b_s;
    logic [31:0] ex_alu_s;
    logic        ex_taken_s;
    logic [31:0] ex_target_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] mem_res_s;

    function automatic logic writes_reg(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: writes_reg = 1'b1;
`ifdef PIPE_MIPS32_MUL_EN
            OP_MUL:                           writes_reg = 1'b1;
`endif
            default:                          writes_reg = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] dest_reg(input logic [31:0] ir);
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: dest_reg = ir[15:11];
            default:                                       dest_reg = ir[20:16];
        endcase
    endfunction

    assign halted      = HALTED;
    assign pc_next_s   = PC + 32'd1;
    assign if_ir_s     = Mem[PC[AW-1:0]];
    assign id_rs_s     = if_id_ir_r[25:21];
    assign id_rt_s     = if_id_ir_r[20:16];
    assign id_hlt_s    = if_id_valid_r && (if_id_ir_r[31:26] == OP_HLT);
    assign wb_we_s     = mem_wb_valid_r && mem_wb_wr_r && (mem_wb_rd_r != 5'd0);
    assign ex_op_s     = id_ex_ir_r[31:26];
    assign ex_rs_s     = id_ex_ir_r[25:21];
    assign ex_rt_s     = id_ex_ir_r[20:16];
    assign ex_imm_s    = {{16{id_ex_ir_r[15]}}, id_ex_ir_r[15:0]};
    assign ex_target_s = id_ex_npc_r + ex_imm_s;
    assign mem_addr_s  = ex_mem_alu_r[AW-1:0];
    assign mem_rdata_s = Mem[mem_addr_s];
    assign mem_res_s   = ex_mem_load_r ? mem_rdata_s : ex_mem_alu_r;

    // ID operand read; a register being written back this cycle is passed straight through
    always_comb begin
        id_a_s = 32'd0;
        id_b_s = 32'd0;
        if (id_rs_s == 5'd0) begin
            id_a_s = 32'd0;
        end else if (wb_we_s && (mem_wb_rd_r == id_rs_s)) begin
            id_a_s = mem_wb_res_r;
        end else begin
            id_a_s = Reg[id_rs_s];
        end
        if (id_rt_s == 5'd0) begin
            id_b_s = 32'd0;
        end else if (wb_we_s && (mem_wb_rd_r == id_rt_s)) begin
            id_b_s = mem_wb_res_r;
        end else begin
            id_b_s = Reg[id_rt_s];
        end
    end

    // EX operand forwarding; EX/MEM is younger than MEM/WB, and a load in EX/MEM has no data yet
    always_comb begin
        ex_a_s = id_ex_a_r;
        ex_b_s = id_ex_b_r;
        if ((ex_rs_s != 5'd0) && ex_mem_valid_r && ex_mem_wr_r && !ex_mem_load_r
                && (ex_mem_rd_r == ex_rs_s)) begin
            ex_a_s = ex_mem_alu_r;
        end else if ((ex_rs_s != 5'd0) && mem_wb_valid_r && mem_wb_wr_r
                && (mem_wb_rd_r == ex_rs_s)) begin
            ex_a_s = mem_wb_res_r;
        end else begin
            ex_a_s = id_ex_a_r;
        end
        if ((ex_rt_s != 5'd0) && ex_mem_valid_r && ex_mem_wr_r && !ex_mem_load_r
                && (ex_mem_rd_r == ex_rt_s)) begin
            ex_b_s = ex_mem_alu_r;
        end else if ((ex_rt_s != 5'd0) && mem_wb_valid_r && mem_wb_wr_r
                && (mem_wb_rd_r == ex_rt_s)) begin
            ex_b_s = mem_wb_res_r;
        end else begin
            ex_b_s = id_ex_b_r;
        end
    end

    // EX ALU, effective address and branch condition
    always_comb begin
        ex_alu_s   = 32'd0;
        ex_taken_s = 1'b0;
        case (ex_op_s)
            OP_ADD:  ex_alu_s = ex_a_s + ex_b_s;
            OP_SUB:  ex_alu_s = ex_a_s - ex_b_s;
            OP_AND:  ex_alu_s = ex_a_s & ex_b_s;
            OP_OR:   ex_alu_s = ex_a_s | ex_b_s;
            OP_SLT:  ex_alu_s = ($signed(ex_a_s) < $signed(ex_b_s)) ? 32'd1 : 32'd0;
`ifdef PIPE_MIPS32_MUL_EN
            OP_MUL:  ex_alu_s = ex_a_s * ex_b_s;
`endif
            OP_ADDI: ex_alu_s = ex_a_s + ex_imm_s;
            OP_SUBI: ex_alu_s = ex_a_s - ex_imm_s;
            OP_SLTI: ex_alu_s = ($signed(ex_a_s) < $signed(ex_imm_s)) ? 32'd1 : 32'd0;
            OP_LW:   ex_alu_s = ex_a_s + ex_imm_s;
            OP_SW:   ex_alu_s = ex_a_s + ex_imm_s;
            OP_BNEZ: ex_taken_s = id_ex_valid_r && (ex_a_s != 32'd0);
            OP_BEQZ: ex_taken_s = id_ex_valid_r && (ex_a_s == 32'd0);
            default: ex_alu_s = 32'd0;
        endcase
    end

    // Pipeline advance and control state; everything holds once HALTED is set
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            PC             <= 32'd0;
            HALTED         <= 1'b0;
            TAKEN_BRANCH   <= 1'b0;
            fetch_stop_r   <= 1'b0;
            if_id_valid_r  <= 1'b0;
            id_ex_valid_r  <= 1'b0;
            ex_mem_valid_r <= 1'b0;
            mem_wb_valid_r <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= ex_taken_s;
            fetch_stop_r <= fetch_stop_r | (id_hlt_s & ~ex_taken_s);
            HALTED       <= mem_wb_valid_r & mem_wb_hlt_r;

            if (ex_taken_s) begin
                PC            <= ex_target_s;
                if_id_valid_r <= 1'b0;
            end else if (fetch_stop_r || id_hlt_s) begin
                if_id_valid_r <= 1'b0;
            end else begin
                PC            <= pc_next_s;
                if_id_valid_r <= 1'b1;
                if_id_ir_r    <= if_ir_s;
                if_id_npc_r   <= pc_next_s;
            end

            id_ex_valid_r <= if_id_valid_r & ~ex_taken_s;
            id_ex_ir_r    <= if_id_ir_r;
            id_ex_npc_r   <= if_id_npc_r;
            id_ex_a_r     <= id_a_s;
            id_ex_b_r     <= id_b_s;

            ex_mem_valid_r <= id_ex_valid_r;
            ex_mem_wr_r    <= id_ex_valid_r && writes_reg(ex_op_s);
            ex_mem_load_r  <= id_ex_valid_r && (ex_op_s == OP_LW);
            ex_mem_store_r <= id_ex_valid_r && (ex_op_s == OP_SW);
            ex_mem_hlt_r   <= id_ex_valid_r && (ex_op_s == OP_HLT);
            ex_mem_rd_r    <= dest_reg(id_ex_ir_r);
            ex_mem_alu_r   <= ex_alu_s;
            ex_mem_b_r     <= ex_b_s;

            mem_wb_valid_r <= ex_mem_valid_r;
            mem_wb_wr_r    <= ex_mem_wr_r;
            mem_wb_hlt_r   <= ex_mem_hlt_r;
            mem_wb_rd_r    <= ex_mem_rd_r;
            mem_wb_res_r   <= mem_res_s;
        end
    end

    // Register write-back and data store; suppressed during reset and while halted
    always_ff @(posedge clk1) begin
        if (rst_n && !HALTED) begin
            if (wb_we_s) begin
                Reg[mem_wb_rd_r] <= mem_wb_res_r;
            end
            if (ex_mem_valid_r && ex_mem_store_r) begin
                Mem[mem_addr_s] <= ex_mem_b_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Bench for pipe_mips32_core: directed programs with fixed expectations, then random
// programs compared against an instruction-level interpreter of the same ISA.
module tb_pipe_mips32_core;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BNEZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_NOP  = 6'b011111;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    logic [31:0] prog  [0:63];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:1023];

    pipe_mips32_core #(.MEM_WORDS(1024)) dut (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] a, b, c;
        a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
        return {op, a, b, c, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [4:0]  a, b;
        logic [15:0] i;
        a = rs[4:0]; b = rt[4:0]; i = imm[15:0];
        return {op, a, b, i};
    endfunction

    // Memory image: zeros, program at word 0; regs: Reg[k] = k
    task automatic init_image(input int n);
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
        for (int i = 0; i < n; i++) m_mem[i] = prog[i];
        for (int k = 0; k < 32; k++) m_reg[k] = k;
    endtask

    // Reset, preload DUT from the model image while reset holds it still, then release
    task automatic start_prog(input string tag);
        @(negedge clk1);
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = m_mem[i];
        for (int k = 0; k < 32; k++) dut.Reg[k] = m_reg[k];
        @(negedge clk1);
        check_eq({tag, "_rst_pc"}, dut.PC, 32'd0);
        check_eq({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string tag);
        int cyc;
        cyc = 0;
        pulses = 0;
        while (!halted && cyc < 500) begin
            @(negedge clk1);
            cyc++;
            if (dut.TAKEN_BRANCH) pulses++;
        end
        check_eq({tag, "_halt"}, {31'd0, halted}, 32'd1);
    endtask

    // Instruction-level interpreter: one instruction at a time, no pipeline notion
    task automatic model_run();
        logic [9:0]  pc;
        logic [31:0] ir, a, b, imm, ea;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        bit done;
        pc = 10'd0;
        done = 1'b0;
        for (int step = 0; step < 2000 && !done; step++) begin
            ir = m_mem[pc];
            op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            a = (rs == 5'd0) ? 32'd0 : m_reg[rs];
            b = (rt == 5'd0) ? 32'd0 : m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea = a + imm;
            pc = pc + 10'd1;
            case (op)
                OP_ADD:  if (rd != 5'd0) m_reg[rd] = a + b;
                OP_SUB:  if (rd != 5'd0) m_reg[rd] = a - b;
                OP_AND:  if (rd != 5'd0) m_reg[rd] = a & b;
                OP_OR:   if (rd != 5'd0) m_reg[rd] = a | b;
                OP_SLT:  if (rd != 5'd0) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef PIPE_MIPS32_MUL_EN
                OP_MUL:  if (rd != 5'd0) m_reg[rd] = a * b;
`endif
                OP_ADDI: if (rt != 5'd0) m_reg[rt] = a + imm;
                OP_SUBI: if (rt != 5'd0) m_reg[rt] = a - imm;
                OP_SLTI: if (rt != 5'd0) m_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                OP_LW:   if (rt != 5'd0) m_reg[rt] = m_mem[ea[9:0]];
                OP_SW:   m_mem[ea[9:0]] = b;
                OP_BNEZ: if (a != 32'd0) pc = pc + imm[9:0];
                OP_BEQZ: if (a == 32'd0) pc = pc + imm[9:0];
                OP_HLT:  done = 1'b1;
                default: ;
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op(input int p);
        case (p)
            0: return OP_ADD;   1: return OP_SUB;   2: return OP_AND;
            3: return OP_OR;    4: return OP_SLT;   5: return OP_MUL;
            6: return OP_ADDI;  7: return OP_SUBI;  8: return OP_SLTI;
            default: return OP_NOP;
        endcase
    endfunction

    // Random program: no load-use within one slot (an independent NOP follows every LW),
    // forward branches only, loads/stores confined to words 512..527 via R0 base
    task automatic gen_random(output int n);
        int idx, pick, maxoff, off;
        n = $urandom_range(20, 40);
        idx = 0;
        while (idx < n - 1) begin
            pick = $urandom_range(0, 14);
            if (pick <= 5) begin
                prog[idx] = enc_r(pick_op(pick), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end else if (pick <= 8) begin
                prog[idx] = enc_i(pick_op(pick), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
            end else if (pick == 9) begin
                prog[idx] = enc_i(OP_LW, 0, $urandom_range(0, 7), 512 + $urandom_range(0, 15));
                if (idx + 1 < n - 1) begin
                    idx++;
                    prog[idx] = enc_i(OP_NOP, 1, 2, 3);
                end
            end else if (pick == 10) begin
                prog[idx] = enc_i(OP_SW, 0, $urandom_range(0, 7), 512 + $urandom_range(0, 15));
            end else if (pick <= 12) begin
                maxoff = n - 2 - idx;
                off = $urandom_range(0, (maxoff < 3) ? maxoff : 3);
                prog[idx] = enc_i((pick == 11) ? OP_BNEZ : OP_BEQZ, $urandom_range(0, 7), 0, off);
            end else begin
                prog[idx] = enc_i(OP_NOP, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
            end
            idx++;
        end
        prog[n - 1] = {OP_HLT, 26'd0};
    endtask

    initial begin
        int n;

        // Reference program: load, add, store with independent fillers
        prog[0] = 32'h28010078; prog[1] = 32'h0c631800;
        prog[2] = 32'h20220000; prog[3] = 32'h0c631800;
        prog[4] = 32'h2842002d; prog[5] = 32'h0c631800;
        prog[6] = 32'h24220001; prog[7] = 32'hfc000000;
        init_image(8);
        m_mem[120] = 32'd85;
        start_prog("ref");
        run_to_halt("ref");
        check_eq("ref_mem121", dut.Mem[121], 32'd130);
        check_eq("ref_mem120", dut.Mem[120], 32'd85);
        check_eq("ref_r1", dut.Reg[1], 32'd120);
        check_eq("ref_r2", dut.Reg[2], 32'd130);
        repeat (5) @(negedge clk1);
        check_eq("frozen_pc", dut.PC, 32'd8);
        check_eq("frozen_halted", {31'd0, halted}, 32'd1);

        // Reset mid-run: the LW write-back edge and the one after it are reset edges
        start_prog("mid");
        repeat (6) @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        check_eq("mid_pc", dut.PC, 32'd0);
        check_eq("mid_halted", {31'd0, halted}, 32'd0);
        @(negedge clk1);
        check_eq("mid_r1", dut.Reg[1], 32'd120);
        check_eq("mid_r2_nowrite", dut.Reg[2], 32'd2);
        check_eq("mid_mem121_nowrite", dut.Mem[121], 32'd0);
        rst_n = 1'b1;
        run_to_halt("mid");
        check_eq("mid_rerun_mem121", dut.Mem[121], 32'd130);
        check_eq("mid_rerun_r2", dut.Reg[2], 32'd130);

        // Back-to-back dependent chain
        prog[0] = enc_i(OP_ADDI, 0, 1, 10);
        prog[1] = enc_r(OP_ADD, 1, 1, 2);
        prog[2] = enc_r(OP_SUB, 2, 1, 3);
        prog[3] = {OP_HLT, 26'd0};
        init_image(4);
        start_prog("chain");
        run_to_halt("chain");
        check_eq("chain_r2", dut.Reg[2], 32'd20);
        check_eq("chain_r3", dut.Reg[3], 32'd10);

        // Taken BEQZ squashes both following writes
        prog[0] = enc_i(OP_BEQZ, 0, 0, 2);
        prog[1] = enc_i(OP_ADDI, 0, 5, 7);
        prog[2] = enc_i(OP_ADDI, 0, 5, 9);
        prog[3] = {OP_HLT, 26'd0};
        init_image(4);
        start_prog("beqz");
        run_to_halt("beqz");
        check_eq("beqz_r5", dut.Reg[5], 32'd5);
        check_eq("beqz_pulses", pulses, 32'd1);

        // Untaken BNEZ falls through
        prog[0] = enc_i(OP_BNEZ, 0, 0, 2);
        prog[1] = enc_i(OP_ADDI, 0, 5, 7);
        prog[2] = enc_i(OP_ADDI, 0, 6, 9);
        prog[3] = {OP_HLT, 26'd0};
        init_image(4);
        start_prog("bnez");
        run_to_halt("bnez");
        check_eq("bnez_r5", dut.Reg[5], 32'd7);
        check_eq("bnez_r6", dut.Reg[6], 32'd9);
        check_eq("bnez_pulses", pulses, 32'd0);

        // Signed SLTI, writes to R0, MUL
        prog[0] = enc_i(OP_SLTI, 6, 4, -1);
        prog[1] = enc_i(OP_SLTI, 6, 9, -2);
        prog[2] = enc_i(OP_ADDI, 0, 0, 5);
        prog[3] = enc_r(OP_ADD, 0, 0, 8);
        prog[4] = enc_r(OP_MUL, 3, 10, 7);
        prog[5] = {OP_HLT, 26'd0};
        init_image(6);
        m_reg[6]  = 32'hFFFFFFFE;
        m_reg[10] = 32'd4;
        start_prog("misc");
        run_to_halt("misc");
        check_eq("slti_r4", dut.Reg[4], 32'd1);
        check_eq("slti_r9", dut.Reg[9], 32'd0);
        check_eq("r0_zero", dut.Reg[0], 32'd0);
        check_eq("r0_read", dut.Reg[8], 32'd0);
`ifdef PIPE_MIPS32_MUL_EN
        check_eq("mul_r7", dut.Reg[7], 32'd12);
`else
        check_eq("mul_r7", dut.Reg[7], 32'd7);
`endif

        // HLT behind a taken branch is squashed; fetch resumes at target
        prog[0] = enc_i(OP_BEQZ, 0, 0, 1);
        prog[1] = {OP_HLT, 26'd0};
        prog[2] = enc_i(OP_ADDI, 0, 9, 33);
        prog[3] = {OP_HLT, 26'd0};
        init_image(4);
        start_prog("sqhlt");
        run_to_halt("sqhlt");
        check_eq("sqhlt_r9", dut.Reg[9], 32'd33);
        check_eq("sqhlt_pulses", pulses, 32'd1);

        // Random programs against the interpreter
        for (int t = 0; t < 12; t++) begin
            gen_random(n);
            init_image(n);
            for (int k = 1; k < 32; k++) m_reg[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            for (int i = 512; i < 528; i++) m_mem[i] = $urandom;
            start_prog($sformatf("rnd%0d", t));
            model_run();
            run_to_halt($sformatf("rnd%0d", t));
            for (int k = 1; k < 8; k++) check_eq($sformatf("rnd%0d_r%0d", t, k), dut.Reg[k], m_reg[k]);
            for (int i = 512; i < 528; i++) check_eq($sformatf("rnd%0d_m%0d", t, i), dut.Mem[i], m_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
